// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared types and helpers for the digit-serial adder sequencer.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } serial_add_state_e;

    // Bits consumed per cycle by the datapath slice.
    localparam int unsigned DIGIT_W = 2;

    // Step counter width: enough to count WIDTH/DIGIT_W steps, never below 1 bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        int unsigned w;
        w = $clog2(width / DIGIT_W);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/two_bit_adder.sv
// two_bit_adder: 2-bit ripple slice with carry in/out, shared across all digits.
module two_bit_adder (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] s,
    output logic       cout
);

    // Combinational 2-bit add of both operands plus carry-in.
    always_comb begin
        {cout, s} = {1'b0, a} + {1'b0, b} + {2'b00, cin};
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: digit-serial adder sequencer. Accepts one WIDTH-bit add over
// a valid/ready handshake, computes it two bits per cycle through a single
// two_bit_adder slice, and presents {cout,sum} over a second valid/ready
// handshake. Define SERIAL_ADD_OVF_EN to add the registered signed-overflow
// output ovf.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam int unsigned STEPS = WIDTH / DIGIT_W;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_width_check
        $error("serial_add_ctrl: WIDTH must be even and >= 2");
    end

    serial_add_state_e state;
    serial_add_state_e state_next;

    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   sum_sh;
    logic [WIDTH-1:0]   sum_sh_next;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic [DIGIT_W-1:0] slice_s;
    logic               slice_cout;
    logic               accept;
    logic               last_step;

    assign accept    = in_valid && in_ready;
    assign last_step = (cnt == LAST_STEP);

    two_bit_adder u_slice (
        .a    (a_sh[DIGIT_W-1:0]),
        .b    (b_sh[DIGIT_W-1:0]),
        .cin  (carry),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // Next sum shift value: shift right one digit, slice result enters at the top.
    always_comb begin
        sum_sh_next = sum_sh >> DIGIT_W;
        sum_sh_next[WIDTH-1 -: DIGIT_W] = slice_s;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            RUN:  busy = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand capture, digit stepping and result registers (updated only on the final step).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> DIGIT_W;
                    b_sh   <= b_sh >> DIGIT_W;
                    sum_sh <= sum_sh_next;
                    carry  <= slice_cout;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_step) begin
                        sum  <= sum_sh_next;
                        cout <= slice_cout;
`ifdef SERIAL_ADD_OVF_EN
                        // Carry into the MSB is recovered from the MSB's sum bit and its operands.
                        ovf  <= a_sh[DIGIT_W-1] ^ b_sh[DIGIT_W-1] ^ slice_s[DIGIT_W-1] ^ slice_cout;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed vectors for serial_add_ctrl (WIDTH=8) with a
// scoreboard queue; a monitor pops and compares on every output handshake.
module tb_serial_add_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             cin = 1'b0;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             in_ready;
    logic             out_valid;
    logic             cout;
    logic             busy;
    logic [WIDTH-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    typedef struct {
        string            name;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_fail = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
`ifdef SERIAL_ADD_OVF_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: compare every completed result against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", out_valid, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, "_sum"}, sum, mon_e.sum);
                check({mon_e.name, "_cout"}, cout, mon_e.cout);
                check({mon_e.name, "_in_ready_low"}, in_ready, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
                check({mon_e.name, "_ovf"}, ovf, mon_e.ovf);
`endif
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("in_ready_wait", in_ready, 1'b1);
    endtask

    // Present one operation; returns at accept edge + 1.
    task automatic send(input string name, input logic [7:0] va, input logic [7:0] vb,
                        input logic vc, input logic [7:0] es, input logic ec,
                        input logic eo, input bit push);
        exp_t e;
        wait_idle();
        a = va;
        b = vb;
        cin = vc;
        in_valid = 1'b1;
        if (push) begin
            e.name = name;
            e.sum  = es;
            e.cout = ec;
            e.ovf  = eo;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Follow an operation until busy drops; reports latency and busy-cycle count.
    task automatic finish_op(output int lat, output int busy_cycles);
        lat = -1;
        busy_cycles = 0;
        for (int k = 0; k < 100; k++) begin
            if (!busy) break;
            busy_cycles++;
            if (out_valid && lat < 0) lat = k;
            @(posedge clk); #1;
        end
        check("op_completes", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bcy;
        int k;

        // Reset values.
        #12;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sum", sum, 8'h00);
        check("rst_cout", cout, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf", ovf, 1'b0);
`endif
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic add with latency and busy length.
        send("v5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 1'b1);
        finish_op(lat, bcy);
        check("latency", lat, 4);
        check("busy_cycles", bcy, 5);

        // Carry-out boundaries.
        send("vff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        finish_op(lat, bcy);
        send("vff_ff_c1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
        finish_op(lat, bcy);
        check("latency_2", lat, 4);

        // Backpressure: DONE holds with stable result.
        out_ready = 1'b0;
        send("v12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("bp_out_valid_rise", out_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_sum_stable", sum, 8'h46);
            check("bp_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_idle", in_ready, 1'b1);
        check("bp_release_out_valid", out_valid, 1'b0);

        // Reset two cycles into RUN discards the operation.
        send("vaa_55", 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_sum", sum, 8'h00);
        check("mid_rst_cout", cout, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_out_valid", out_valid, 1'b0);
        end
        send("v01_01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
        finish_op(lat, bcy);

        // Operand changes and held in_valid during RUN are ignored.
        wait_idle();
        a = 8'h33;
        b = 8'h44;
        cin = 1'b1;
        in_valid = 1'b1;
        exp_q.push_back('{name: "v33_44_c1", sum: 8'h78, cout: 1'b0, ovf: 1'b0});
        @(posedge clk); #1;
        a = 8'hFF;
        b = 8'hFF;
        cin = 1'b0;
        check("run_in_ready_low", in_ready, 1'b0);
        @(posedge clk); #1;
        a = 8'h00;
        b = 8'h81;
        check("run_in_ready_low_2", in_ready, 1'b0);
        in_valid = 1'b0;
        finish_op(lat, bcy);

        // Signed overflow boundaries (ovf compared only when the port exists).
        send("v7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
        finish_op(lat, bcy);
        send("v80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        finish_op(lat, bcy);
        send("v10_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b1);
        finish_op(lat, bcy);

        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
